ldi_sti_sequencer: RTL and testbench
====================================

LDI_STI_SEQUENCER -- requirements
Module: ldi_sti_sequencer

Interface
REQ-001 Ports SHALL be as listed; all are synchronous to clk.
  - clk  input  1  sole clock; all state updates on its rising edge.
  - reset  input  1  synchronous, active-high reset.
  - EX_MEM_opcode  input  lc3b_opcode (4)  opcode currently in the EX/MEM stage.
  - dcache_resp  input  1  D-cache access complete this cycle.
  - mem_rdata  input  lc3b_word (16)  D-cache read data.
  - load_LDI_STI_ADDRESS  input  1  from stall/reset logic; pointer-read phase active.
  - reset_LDI_STI_counter  input  1  from stall/reset logic; indirect op retiring.
  - counter  output  2  indirect phase count (00 pointer read, 01 data access, 10 complete).
  - indirect_address  output  lc3b_word  latched pointer for the second access.
  - indirect_busy  output  1  high while counter != 00.
  - seq_error  output  1  sticky protocol-violation flag.
  - indirect_count  output  16  saturating count of retired LDI/STI ops.

Function
REQ-002 The block SHALL hold the state machine IDLE (counter 00), PTR_DONE (counter 01) and DATA_DONE (counter 10); counter SHALL be a registered encoding of the state.
REQ-003 IDLE->PTR_DONE SHALL occur only when EX_MEM_opcode is op_ldi or op_sti, load_LDI_STI_ADDRESS=1 and dcache_resp=1.
REQ-004 On the REQ-003 transition, indirect_address SHALL load mem_rdata with bit 0 forced to 0 (word-aligned).
REQ-005 PTR_DONE->DATA_DONE SHALL occur when EX_MEM_opcode is op_ldi or op_sti and dcache_resp=1.
REQ-006 DATA_DONE->IDLE SHALL occur when reset_LDI_STI_counter=1.
REQ-007 Without a qualifying event, the block SHALL hold its state.
REQ-008 When reset_LDI_STI_counter=1 in IDLE or PTR_DONE, the next state SHALL be IDLE.
REQ-009 reset_LDI_STI_counter SHALL take priority over any same-cycle advance condition.
REQ-010 When counter != 00, EX_MEM_opcode is neither op_ldi nor op_sti, and reset_LDI_STI_counter=0, the next state SHALL be IDLE and seq_error SHALL set.
REQ-011 When reset_LDI_STI_counter=1 in state IDLE, seq_error SHALL set.
REQ-012 Once set, seq_error SHALL remain set until reset.
REQ-013 indirect_address SHALL change only per REQ-004 and SHALL otherwise hold its value.
REQ-014 indirect_address SHALL hold its value through IDLE, so its value after retirement equals the last pointer.
REQ-015 indirect_busy SHALL be combinational from the state: 1 in PTR_DONE and DATA_DONE, 0 in IDLE.
REQ-016 indirect_count SHALL increment by 1 on each DATA_DONE->IDLE transition.
REQ-017 indirect_count SHALL saturate at 16'hFFFF.
REQ-018 dcache_resp while in DATA_DONE SHALL NOT alter any state.
REQ-019 All state changes SHALL take effect on the clock edge after the qualifying inputs, so counter has one-cycle latency.
REQ-020 No output SHALL combinationally depend on dcache_resp or mem_rdata.

Reset
REQ-021 With reset=1 at a rising edge, the block SHALL return to IDLE (counter=00), with indirect_address=16'h0000, seq_error=0, indirect_count=0 and indirect_busy=0.
REQ-022 Reset SHALL override every other input, including mid-sequence in PTR_DONE or DATA_DONE.
REQ-023 The block SHALL ignore all inputs during the reset cycle.

Structure
REQ-024 lc3b_opcode, lc3b_word, op_ldi and op_sti SHALL come from lc3b_types.
REQ-025 A new enum lc3b_indirect_state (IDLE=2'b00, PTR_DONE=2'b01, DATA_DONE=2'b10) SHALL be added to lc3b_types.
REQ-026 The saturating counter SHALL be the sub-module sat_counter16, with ports clk, reset, inc and count.
REQ-027 All other logic SHALL be in a single module with one sequential process and one next-state combinational process.

Verification
REQ-028 Scenario: LDI with a two-cycle miss, then resp with mem_rdata=16'h3A41, then resp, then reset_LDI_STI_counter -> counter 00,00,01,10,00; indirect_address=16'h3A40; indirect_count=1.
REQ-029 Scenario: STI with single-cycle hits on both accesses -> counter reaches 01 and then 10 on consecutive edges; indirect_busy high for exactly 2 cycles before clear.
REQ-030 Scenario: in PTR_DONE, EX_MEM_opcode changes to op_add -> counter 00 and seq_error=1 next cycle; seq_error still 1 after 5 idle cycles.
REQ-031 Scenario: in PTR_DONE, dcache_resp=1 together with reset_LDI_STI_counter=1 -> counter 00 and indirect_count unchanged.
REQ-032 Scenario: reset asserted in DATA_DONE -> all outputs at REQ-021 values on the next cycle.
REQ-033 Scenario: preload indirect_count=16'hFFFE, then run 3 complete LDIs -> indirect_count=16'hFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types
//   Shared LC-3b types: opcode and word types, plus the state encoding of
//   the LDI/STI indirect-access sequencer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // Indirect phase: the value doubles as the externally visible counter.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PTR_DONE  = 2'b01,
        DATA_DONE = 2'b10
    } lc3b_indirect_state;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16
//   16-bit up counter that sticks at 16'hFFFF.
//   clk   : clock (rising edge)
//   reset : synchronous active-high reset, loads INIT
//   inc   : add one this cycle unless already saturated
//   count : current count
module sat_counter16 #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= INIT;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ldi_sti_sequencer.sv
// ldi_sti_sequencer
//   Tracks the two D-cache accesses of an LC-3b LDI/STI: the pointer read
//   and the data access. Latches the (word-aligned) pointer for the second
//   access, flags protocol violations, and counts retired indirect ops.
//   clk                   : clock (rising edge)
//   reset                 : synchronous active-high reset
//   EX_MEM_opcode         : opcode in EX/MEM
//   dcache_resp           : D-cache access complete this cycle
//   mem_rdata             : D-cache read data
//   load_LDI_STI_ADDRESS  : pointer-read phase active
//   reset_LDI_STI_counter : indirect op retiring
//   counter               : 00 pointer read, 01 data access, 10 complete
//   indirect_address      : latched pointer
//   indirect_busy         : counter != 00
//   seq_error             : sticky protocol-violation flag
//   indirect_count        : saturating count of retired indirect ops
module ldi_sti_sequencer
    import lc3b_types::*;
#(
    parameter logic [15:0] COUNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  lc3b_opcode  EX_MEM_opcode,
    input  logic        dcache_resp,
    input  lc3b_word    mem_rdata,
    input  logic        load_LDI_STI_ADDRESS,
    input  logic        reset_LDI_STI_counter,
    output logic [1:0]  counter,
    output lc3b_word    indirect_address,
    output logic        indirect_busy,
    output logic        seq_error,
    output logic [15:0] indirect_count
);

    lc3b_indirect_state r_state;
    lc3b_indirect_state w_next;
    lc3b_word           r_addr;
    logic               r_err;
    logic               w_is_ind;
    logic               w_load_ptr;
    logic               w_set_err;
    logic               w_inc;

    assign w_is_ind = (EX_MEM_opcode == op_ldi) || (EX_MEM_opcode == op_sti);

    always_comb begin
        w_next     = r_state;
        w_load_ptr = 1'b0;
        w_set_err  = 1'b0;
        if (reset_LDI_STI_counter) begin
            // Retirement wins over any same-cycle advance; retiring with
            // nothing in flight is a protocol violation.
            w_next    = IDLE;
            w_set_err = (r_state == IDLE);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_is_ind && load_LDI_STI_ADDRESS && dcache_resp) begin
                        w_next     = PTR_DONE;
                        w_load_ptr = 1'b1;
                    end
                end
                PTR_DONE: begin
                    if (!w_is_ind) begin
                        w_next    = IDLE;
                        w_set_err = 1'b1;
                    end else if (dcache_resp) begin
                        w_next = DATA_DONE;
                    end
                end
                DATA_DONE: begin
                    if (!w_is_ind) begin
                        w_next    = IDLE;
                        w_set_err = 1'b1;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    assign w_inc = (r_state == DATA_DONE) && (w_next == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load_ptr) begin
                r_addr <= {mem_rdata[15:1], 1'b0};
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    sat_counter16 #(
        .INIT (COUNT_INIT)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc && !reset),
        .count (indirect_count)
    );

    assign counter          = r_state;
    assign indirect_address = r_addr;
    assign indirect_busy    = (r_state != IDLE);
    assign seq_error        = r_err;

endmodule

// File: tb/tb_ldi_sti_sequencer.sv
// tb_ldi_sti_sequencer
//   Table of input/expected-output vectors plus hand-written sequences for
//   the multi-cycle cases. A second instance with a preloaded count covers
//   saturation.
module tb_ldi_sti_sequencer;
    import lc3b_types::*;

    typedef struct {
        logic        rst;
        lc3b_opcode  op;
        logic        resp;
        logic [15:0] rdata;
        logic        ld;
        logic        rc;
        logic [1:0]  e_cnt;
        logic [15:0] e_addr;
        logic        e_err;
        logic [15:0] e_ic;
        logic        chk_sat;
        logic [15:0] e_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    lc3b_opcode  opcode = op_add;
    logic        resp = 1'b0;
    logic [15:0] rdata = '0;
    logic        ld = 1'b0;
    logic        rc = 1'b0;

    logic [1:0]  d_cnt,  s_cnt;
    logic [15:0] d_addr, s_addr;
    logic        d_busy, s_busy;
    logic        d_err,  s_err;
    logic [15:0] d_ic,   s_ic;

    int n_cmp = 0;
    int n_bad = 0;
    int step  = 0;
    vec_t sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    ldi_sti_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .EX_MEM_opcode         (opcode),
        .dcache_resp           (resp),
        .mem_rdata             (rdata),
        .load_LDI_STI_ADDRESS  (ld),
        .reset_LDI_STI_counter (rc),
        .counter               (d_cnt),
        .indirect_address      (d_addr),
        .indirect_busy         (d_busy),
        .seq_error             (d_err),
        .indirect_count        (d_ic)
    );

    ldi_sti_sequencer #(
        .COUNT_INIT (16'hFFFE)
    ) dut_sat (
        .clk                   (clk),
        .reset                 (reset),
        .EX_MEM_opcode         (opcode),
        .dcache_resp           (resp),
        .mem_rdata             (rdata),
        .load_LDI_STI_ADDRESS  (ld),
        .reset_LDI_STI_counter (rc),
        .counter               (s_cnt),
        .indirect_address      (s_addr),
        .indirect_busy         (s_busy),
        .seq_error             (s_err),
        .indirect_count        (s_ic)
    );

    function automatic vec_t mk(input logic r, input lc3b_opcode o, input logic rs,
                                input logic [15:0] rd, input logic l, input logic c,
                                input logic [1:0] ec, input logic [15:0] ea,
                                input logic ee, input logic [15:0] ei,
                                input logic cs, input logic [15:0] es);
        vec_t v;
        v.rst = r; v.op = o; v.resp = rs; v.rdata = rd; v.ld = l; v.rc = c;
        v.e_cnt = ec; v.e_addr = ea; v.e_err = ee; v.e_ic = ei;
        v.chk_sat = cs; v.e_sat = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset  = v.rst;
        opcode = v.op;
        resp   = v.resp;
        rdata  = v.rdata;
        ld     = v.ld;
        rc     = v.rc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("counter", {14'd0, d_cnt}, {14'd0, e.e_cnt});
        chk("indirect_address", d_addr, e.e_addr);
        chk("indirect_busy", {15'd0, d_busy}, {15'd0, (e.e_cnt != 2'b00)});
        chk("seq_error", {15'd0, d_err}, {15'd0, e.e_err});
        chk("indirect_count", d_ic, e.e_ic);
        if (e.chk_sat) begin
            chk("sat_counter", {14'd0, s_cnt}, {14'd0, e.e_cnt});
            chk("sat_address", s_addr, e.e_addr);
            chk("sat_busy", {15'd0, s_busy}, {15'd0, (e.e_cnt != 2'b00)});
            chk("sat_error", {15'd0, s_err}, {15'd0, e.e_err});
            chk("sat_count", s_ic, e.e_sat);
        end
        step++;
    endtask

    initial begin
        //           rst op      resp rdata     ld  rc  cnt    addr      err ic     sat
        tbl[0]  = mk(1, op_add,  0, 16'h0000, 0, 0, 2'b00, 16'h0000, 0, 16'd0, 1, 16'hFFFE);
        // LDI with two miss cycles on the pointer read
        tbl[1]  = mk(0, op_ldi,  0, 16'h0000, 1, 0, 2'b00, 16'h0000, 0, 16'd0, 0, 16'h0);
        tbl[2]  = mk(0, op_ldi,  0, 16'h0000, 1, 0, 2'b00, 16'h0000, 0, 16'd0, 0, 16'h0);
        tbl[3]  = mk(0, op_ldi,  1, 16'h3A41, 1, 0, 2'b01, 16'h3A40, 0, 16'd0, 0, 16'h0);
        tbl[4]  = mk(0, op_ldi,  1, 16'hBEEF, 0, 0, 2'b10, 16'h3A40, 0, 16'd0, 0, 16'h0);
        // resp in DATA_DONE changes nothing
        tbl[5]  = mk(0, op_ldi,  1, 16'h1234, 1, 0, 2'b10, 16'h3A40, 0, 16'd0, 0, 16'h0);
        tbl[6]  = mk(0, op_ldi,  0, 16'h0000, 0, 1, 2'b00, 16'h3A40, 0, 16'd1, 0, 16'h0);
        // non-indirect opcode in IDLE: no start, no error
        tbl[7]  = mk(0, op_add,  1, 16'hFFFF, 1, 0, 2'b00, 16'h3A40, 0, 16'd1, 0, 16'h0);
        tbl[8]  = mk(0, op_ldi,  0, 16'h5555, 1, 0, 2'b00, 16'h3A40, 0, 16'd1, 0, 16'h0);
        // STI, single-cycle hits: busy for exactly two cycles
        tbl[9]  = mk(0, op_sti,  1, 16'h8001, 1, 0, 2'b01, 16'h8000, 0, 16'd1, 0, 16'h0);
        tbl[10] = mk(0, op_sti,  1, 16'h4321, 0, 0, 2'b10, 16'h8000, 0, 16'd1, 0, 16'h0);
        tbl[11] = mk(0, op_sti,  0, 16'h0000, 0, 1, 2'b00, 16'h8000, 0, 16'd2, 0, 16'h0);
        // retire in PTR_DONE beats same-cycle resp, no count
        tbl[12] = mk(0, op_ldi,  1, 16'h0103, 1, 0, 2'b01, 16'h0102, 0, 16'd2, 0, 16'h0);
        tbl[13] = mk(0, op_ldi,  1, 16'h9999, 0, 1, 2'b00, 16'h0102, 0, 16'd2, 0, 16'h0);
        // retire in IDLE is an error
        tbl[14] = mk(0, op_add,  0, 16'h0000, 0, 1, 2'b00, 16'h0102, 1, 16'd2, 0, 16'h0);
        tbl[15] = mk(1, op_ldi,  1, 16'h7777, 1, 1, 2'b00, 16'h0000, 0, 16'd0, 1, 16'hFFFE);

        for (int unsigned i = 0; i < 16; i++) begin
            apply(tbl[i]);
        end

        // Reset in DATA_DONE with a nonzero count and junk on every input
        apply(mk(0, op_ldi, 1, 16'hABCD, 1, 0, 2'b01, 16'hABCC, 0, 16'd0, 0, 16'h0));
        apply(mk(0, op_ldi, 1, 16'h0000, 0, 0, 2'b10, 16'hABCC, 0, 16'd0, 0, 16'h0));
        apply(mk(0, op_ldi, 0, 16'h0000, 0, 1, 2'b00, 16'hABCC, 0, 16'd1, 0, 16'h0));
        apply(mk(0, op_sti, 1, 16'h1357, 1, 0, 2'b01, 16'h1356, 0, 16'd1, 0, 16'h0));
        apply(mk(0, op_sti, 1, 16'h0000, 0, 0, 2'b10, 16'h1356, 0, 16'd1, 0, 16'h0));
        apply(mk(1, op_ldi, 1, 16'hFFFF, 1, 1, 2'b00, 16'h0000, 0, 16'd0, 1, 16'hFFFE));

        // Opcode drops out in PTR_DONE: abort and sticky error
        apply(mk(0, op_ldi, 1, 16'h7777, 1, 0, 2'b01, 16'h7776, 0, 16'd0, 0, 16'h0));
        apply(mk(0, op_add, 1, 16'h0000, 0, 0, 2'b00, 16'h7776, 1, 16'd0, 0, 16'h0));
        for (int unsigned i = 0; i < 5; i++) begin
            apply(mk(0, op_add, 0, 16'h0000, 0, 0, 2'b00, 16'h7776, 1, 16'd0, 0, 16'h0));
        end

        // Saturation: second instance starts at FFFE, three LDIs
        apply(mk(1, op_add, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 0, 16'd0, 1, 16'hFFFE));
        for (int unsigned i = 0; i < 3; i++) begin
            logic [15:0] sat_before;
            logic [15:0] ptr;
            sat_before = (i == 0) ? 16'hFFFE : 16'hFFFF;
            ptr = 16'h2000 + 16'(i * 3);
            apply(mk(0, op_ldi, 1, ptr, 1, 0, 2'b01, {ptr[15:1], 1'b0}, 0, 16'(i), 1, sat_before));
            apply(mk(0, op_ldi, 1, 16'h0000, 0, 0, 2'b10, {ptr[15:1], 1'b0}, 0, 16'(i), 1, sat_before));
            apply(mk(0, op_ldi, 0, 16'h0000, 0, 1, 2'b00, {ptr[15:1], 1'b0}, 0, 16'(i + 1), 1, 16'hFFFF));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
